tile_scheduler: RTL and testbench

- Sequences output tiles of a C = A x B job (M x K by K x N, 8-bit dims) onto the DIM x DIM systolic-array datapath.
- Issues one command per output tile over a valid/ready handshake. Each command carries the tile indices, the A/B/C buffer base indices and the edge-tile row/column counts.
- Waits for the datapath's tile_done before issuing the next command.
- Sits between the host job interface (in_valid/K/M/N/busy) and the load/calc/writeback datapath.

---
 rtl/tile_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_tile_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_scheduler.sv
// rtl/tile_scheduler.sv - issues one systolic-array command per output tile of a C = A x B job
module tile_scheduler #(
    parameter int DIM   = 4,
    parameter int IDX_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       K,
    input  logic [7:0]       M,
    input  logic [7:0]       N,
    output logic             busy,
    output logic             done,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [7:0]       cmd_tile_m,
    output logic [7:0]       cmd_tile_n,
    output logic [IDX_W-1:0] cmd_a_base,
    output logic [IDX_W-1:0] cmd_b_base,
    output logic [IDX_W-1:0] cmd_c_base,
    output logic [7:0]       cmd_k_len,
    output logic [2:0]       cmd_rows,
    output logic [2:0]       cmd_cols,
    output logic             cmd_last,
    input  logic             tile_done
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIN} state_t;

    state_t           state_q, state_d;
    logic [7:0]       m_q, m_d, n_q, n_d, k_q, k_d;
    logic [8:0]       tm_max_q, tm_max_d, tn_max_q, tn_max_d;
    logic [7:0]       tile_m_q, tile_m_d, tile_n_q, tile_n_d;
    logic             busy_q, busy_d, done_q, done_d, valid_q, valid_d;
    logic [IDX_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [7:0]       klen_q, klen_d;
    logic [2:0]       rows_q, rows_d, cols_q, cols_d;
    logic             last_q, last_d;

    // Job geometry comes straight from the inputs while IDLE, from latched copies afterwards.
    logic [7:0]       src_m, src_n, src_k;
    logic [8:0]       src_tm_max, src_tn_max;
    logic [8:0]       in_tm_max, in_tn_max;
    logic [IDX_W-1:0] a_nxt, b_nxt, c_nxt, rem_m, rem_n;
    logic [2:0]       rows_nxt, cols_nxt;
    logic             last_nxt, load_fields;

    assign in_tm_max  = ({1'b0, M} + 9'(DIM - 1)) / 9'(DIM);
    assign in_tn_max  = ({1'b0, N} + 9'(DIM - 1)) / 9'(DIM);
    assign src_m      = (state_q == S_IDLE) ? M : m_q;
    assign src_n      = (state_q == S_IDLE) ? N : n_q;
    assign src_k      = (state_q == S_IDLE) ? K : k_q;
    assign src_tm_max = (state_q == S_IDLE) ? in_tm_max : tm_max_q;
    assign src_tn_max = (state_q == S_IDLE) ? in_tn_max : tn_max_q;

    assign a_nxt    = IDX_W'(tile_m_d) * IDX_W'(src_k);
    assign b_nxt    = IDX_W'(tile_n_d) * IDX_W'(src_k);
    assign c_nxt    = IDX_W'(tile_n_d) * IDX_W'(src_m) + IDX_W'(tile_m_d) * IDX_W'(DIM);
    assign rem_m    = IDX_W'(src_m) - IDX_W'(tile_m_d) * IDX_W'(DIM);
    assign rem_n    = IDX_W'(src_n) - IDX_W'(tile_n_d) * IDX_W'(DIM);
    assign rows_nxt = (rem_m >= IDX_W'(DIM)) ? 3'(DIM) : rem_m[2:0];
    assign cols_nxt = (rem_n >= IDX_W'(DIM)) ? 3'(DIM) : rem_n[2:0];
    assign last_nxt = ({1'b0, tile_m_d} == src_tm_max - 9'd1) &&
                      ({1'b0, tile_n_d} == src_tn_max - 9'd1);

    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        n_d         = n_q;
        k_d         = k_q;
        tm_max_d    = tm_max_q;
        tn_max_d    = tn_max_q;
        tile_m_d    = tile_m_q;
        tile_n_d    = tile_n_q;
        busy_d      = busy_q;
        done_d      = done_q;
        valid_d     = valid_q;
        load_fields = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    m_d      = M;
                    n_d      = N;
                    k_d      = K;
                    tm_max_d = in_tm_max;
                    tn_max_d = in_tn_max;
                    tile_m_d = 8'd0;
                    tile_n_d = 8'd0;
                    busy_d   = 1'b1;
                    if (M == 8'd0 || N == 8'd0 || K == 8'd0) begin
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        valid_d     = 1'b1;
                        load_fields = 1'b1;
                        state_d     = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    valid_d = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tile_done) begin
                    if (last_q) begin
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        // n is the inner loop: wrap it and bump m at the row end.
                        if ({1'b0, tile_n_q} == tn_max_q - 9'd1) begin
                            tile_n_d = 8'd0;
                            tile_m_d = tile_m_q + 8'd1;
                        end else begin
                            tile_n_d = tile_n_q + 8'd1;
                        end
                        valid_d     = 1'b1;
                        load_fields = 1'b1;
                        state_d     = S_ISSUE;
                    end
                end
            end
            S_FIN: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        c_d    = c_q;
        klen_d = klen_q;
        rows_d = rows_q;
        cols_d = cols_q;
        last_d = last_q;
        if (load_fields) begin
            a_d    = a_nxt;
            b_d    = b_nxt;
            c_d    = c_nxt;
            klen_d = src_k;
            rows_d = rows_nxt;
            cols_d = cols_nxt;
            last_d = last_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            m_q      <= '0;
            n_q      <= '0;
            k_q      <= '0;
            tm_max_q <= '0;
            tn_max_q <= '0;
            tile_m_q <= '0;
            tile_n_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            klen_q   <= '0;
            rows_q   <= '0;
            cols_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            n_q      <= n_d;
            k_q      <= k_d;
            tm_max_q <= tm_max_d;
            tn_max_q <= tn_max_d;
            tile_m_q <= tile_m_d;
            tile_n_q <= tile_n_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            klen_q   <= klen_d;
            rows_q   <= rows_d;
            cols_q   <= cols_d;
            last_q   <= last_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign cmd_valid  = valid_q;
    assign cmd_tile_m = tile_m_q;
    assign cmd_tile_n = tile_n_q;
    assign cmd_a_base = a_q;
    assign cmd_b_base = b_q;
    assign cmd_c_base = c_q;
    assign cmd_k_len  = klen_q;
    assign cmd_rows   = rows_q;
    assign cmd_cols   = cols_q;
    assign cmd_last   = last_q;

endmodule

// File: tb/tb_tile_scheduler.sv
// tb/tb_tile_scheduler.sv - directed self-checking bench for tile_scheduler
module tb_tile_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  K = 8'd0, M = 8'd0, N = 8'd0;
    logic        busy, done, cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [7:0]  cmd_tile_m, cmd_tile_n, cmd_k_len;
    logic [15:0] cmd_a_base, cmd_b_base, cmd_c_base;
    logic [2:0]  cmd_rows, cmd_cols;
    logic        cmd_last;
    logic        tile_done = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [78:0] cmd_bus;
    assign cmd_bus = {cmd_tile_m, cmd_tile_n, cmd_a_base, cmd_b_base, cmd_c_base,
                      cmd_k_len, cmd_rows, cmd_cols, cmd_last};

    tile_scheduler #(.DIM(4), .IDX_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .K(K), .M(M), .N(N),
        .busy(busy), .done(done), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_tile_m(cmd_tile_m), .cmd_tile_n(cmd_tile_n),
        .cmd_a_base(cmd_a_base), .cmd_b_base(cmd_b_base), .cmd_c_base(cmd_c_base),
        .cmd_k_len(cmd_k_len), .cmd_rows(cmd_rows), .cmd_cols(cmd_cols),
        .cmd_last(cmd_last), .tile_done(tile_done)
    );

    always #5 clk = ~clk;

    task automatic start_job(input logic [7:0] m, input logic [7:0] n, input logic [7:0] k);
        @(negedge clk);
        M = m; N = n; K = k; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({busy, done, cmd_valid, cmd_bus} !== 82'd0)
            $display("FAIL reset_outputs: got %h expected 0", {busy, done, cmd_valid, cmd_bus});
        rst = 1'b0;
    endtask

    task automatic test_single;
        cmd_ready = 1'b1;
        start_job(8'd4, 8'd4, 8'd4);
        checks++;
        if (cmd_valid !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL t1_valid_busy: got %b%b expected 11", cmd_valid, busy);
        end
        checks++;
        if (cmd_bus !== {8'd0, 8'd0, 16'd0, 16'd0, 16'd0, 8'd4, 3'd4, 3'd4, 1'b1}) begin
            errors++; $display("FAIL t1_fields: got %h expected %h", cmd_bus,
                {8'd0, 8'd0, 16'd0, 16'd0, 16'd0, 8'd4, 3'd4, 3'd4, 1'b1});
        end
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++; $display("FAIL t1_valid_drop: got %b expected 0", cmd_valid);
        end
        repeat (4) @(negedge clk);
        tile_done = 1'b1;
        @(negedge clk);
        tile_done = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL t1_done: got done=%b busy=%b expected 1 1", done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL t1_idle: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_tiles_8x8;
        logic [7:0]  etm[4] = '{8'd0, 8'd0, 8'd1, 8'd1};
        logic [7:0]  etn[4] = '{8'd0, 8'd1, 8'd0, 8'd1};
        logic [15:0] ea[4]  = '{16'd0, 16'd0, 16'd5, 16'd5};
        logic [15:0] eb[4]  = '{16'd0, 16'd5, 16'd0, 16'd5};
        logic [15:0] ec[4]  = '{16'd0, 16'd8, 16'd4, 16'd12};
        logic        el[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
        cmd_ready = 1'b1;
        start_job(8'd8, 8'd8, 8'd5);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cmd_valid !== 1'b1) begin
                errors++; $display("FAIL t2_valid[%0d]: got %b expected 1", i, cmd_valid);
            end
            checks++;
            if (cmd_bus !== {etm[i], etn[i], ea[i], eb[i], ec[i], 8'd5, 3'd4, 3'd4, el[i]}) begin
                errors++; $display("FAIL t2_fields[%0d]: got %h expected %h", i, cmd_bus,
                    {etm[i], etn[i], ea[i], eb[i], ec[i], 8'd5, 3'd4, 3'd4, el[i]});
            end
            @(negedge clk);
            checks++;
            if (cmd_valid !== 1'b0 || done !== 1'b0) begin
                errors++; $display("FAIL t2_wait[%0d]: got valid=%b done=%b expected 0 0", i, cmd_valid, done);
            end
            tile_done = 1'b1;
            @(negedge clk);
            tile_done = 1'b0;
        end
        checks++;
        if (done !== 1'b1 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL t2_done: got done=%b valid=%b expected 1 0", done, cmd_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_edge_tiles;
        logic [7:0]  etm[4] = '{8'd0, 8'd0, 8'd1, 8'd1};
        logic [7:0]  etn[4] = '{8'd0, 8'd1, 8'd0, 8'd1};
        logic [15:0] ea[4]  = '{16'd0, 16'd0, 16'd3, 16'd3};
        logic [15:0] eb[4]  = '{16'd0, 16'd3, 16'd0, 16'd3};
        logic [15:0] ec[4]  = '{16'd0, 16'd6, 16'd4, 16'd10};
        logic [2:0]  er[4]  = '{3'd4, 3'd4, 3'd2, 3'd2};
        logic [2:0]  eco[4] = '{3'd4, 3'd1, 3'd4, 3'd1};
        logic        el[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
        cmd_ready = 1'b1;
        start_job(8'd6, 8'd5, 8'd3);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cmd_valid !== 1'b1 ||
                cmd_bus !== {etm[i], etn[i], ea[i], eb[i], ec[i], 8'd3, er[i], eco[i], el[i]}) begin
                errors++; $display("FAIL t3_cmd[%0d]: got valid=%b %h expected 1 %h", i, cmd_valid, cmd_bus,
                    {etm[i], etn[i], ea[i], eb[i], ec[i], 8'd3, er[i], eco[i], el[i]});
            end
            @(negedge clk);
            tile_done = 1'b1;
            @(negedge clk);
            tile_done = 1'b0;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL t3_done: got %b expected 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        cmd_ready = 1'b0;
        start_job(8'd4, 8'd4, 8'd4);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (cmd_valid !== 1'b1 ||
                cmd_bus !== {8'd0, 8'd0, 16'd0, 16'd0, 16'd0, 8'd4, 3'd4, 3'd4, 1'b1}) begin
                errors++; $display("FAIL t4_hold[%0d]: got valid=%b %h", i, cmd_valid, cmd_bus);
            end
            tile_done = (i == 3);
            @(negedge clk);
        end
        // Handshake cycle carries a tile_done that must not count as completion.
        cmd_ready = 1'b1;
        tile_done = 1'b1;
        @(negedge clk);
        tile_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cmd_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL t4_wait[%0d]: got valid=%b done=%b busy=%b expected 0 0 1",
                    i, cmd_valid, done, busy);
            end
            @(negedge clk);
        end
        tile_done = 1'b1;
        @(negedge clk);
        tile_done = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL t4_done: got %b expected 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_dim;
        cmd_ready = 1'b1;
        start_job(8'd4, 8'd4, 8'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL t5_t1: got done=%b busy=%b valid=%b expected 1 1 0", done, busy, cmd_valid);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL t5_t2: got done=%b busy=%b valid=%b expected 0 0 0", done, busy, cmd_valid);
        end
    endtask

    task automatic test_reset_restart;
        logic [7:0]  etm[4] = '{8'd0, 8'd0, 8'd1, 8'd1};
        logic [7:0]  etn[4] = '{8'd0, 8'd1, 8'd0, 8'd1};
        logic [15:0] ea[4]  = '{16'd0, 16'd0, 16'd5, 16'd5};
        logic [15:0] ec[4]  = '{16'd0, 16'd8, 16'd4, 16'd12};
        cmd_ready = 1'b1;
        start_job(8'd8, 8'd8, 8'd5);
        @(negedge clk);
        tile_done = 1'b1;
        @(negedge clk);
        tile_done = 1'b0;
        checks++;
        if (cmd_valid !== 1'b1 || cmd_tile_n !== 8'd1) begin
            errors++; $display("FAIL t6_tile01: got valid=%b n=%0d expected 1 1", cmd_valid, cmd_tile_n);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, cmd_valid, cmd_bus} !== 82'd0) begin
            errors++; $display("FAIL t6_async_reset: got %h expected 0", {busy, done, cmd_valid, cmd_bus});
        end
        @(negedge clk);
        rst = 1'b0;
        start_job(8'd8, 8'd8, 8'd5);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cmd_valid !== 1'b1 || cmd_tile_m !== etm[i] || cmd_tile_n !== etn[i] ||
                cmd_a_base !== ea[i] || cmd_c_base !== ec[i] || cmd_k_len !== 8'd5) begin
                errors++; $display("FAIL t6_restart[%0d]: got valid=%b m=%0d n=%0d a=%0d c=%0d k=%0d expected 1 %0d %0d %0d %0d 5",
                    i, cmd_valid, cmd_tile_m, cmd_tile_n, cmd_a_base, cmd_c_base, cmd_k_len,
                    etm[i], etn[i], ea[i], ec[i]);
            end
            @(negedge clk);
            if (i == 1) begin
                M = 8'd4; N = 8'd4; K = 8'd4; in_valid = 1'b1;
            end
            tile_done = 1'b1;
            @(negedge clk);
            tile_done = 1'b0;
            in_valid  = 1'b0;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL t6_done: got %b expected 1", done);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL t6_idle: got busy=%b valid=%b expected 0 0", busy, cmd_valid);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_tiles_8x8;
        test_edge_tiles;
        test_backpressure;
        test_zero_dim;
        test_reset_restart;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
